// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - prescaled 12-bit up-counter with start/stop/clear control,
// one-shot or continuous-wrap modes and a loadable terminal count.
module counter_ctrl #(
  parameter int unsigned PRESCALE   = 4,
  parameter logic [11:0] DEFAULT_TC = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        mode,
  input  logic        tc_load,
  input  logic [11:0] tc_value,
  output logic [11:0] counter,
  output logic [1:0]  state,
  output logic        busy,
  output logic        done,
  output logic        wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        st;
  logic [PW-1:0] prescaler;
  logic [11:0]   tc;
  logic          tick;

  assign tick  = (st == RUN) && (prescaler == PS_LAST);
  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      counter   <= '0;
      prescaler <= '0;
      tc        <= DEFAULT_TC;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        st        <= IDLE;
        counter   <= '0;
        prescaler <= '0;
        busy      <= 1'b0;
      end else begin
        unique case (st)
          IDLE: begin
            if (tc_load) tc <= tc_value;
            if (start) begin
              st        <= RUN;
              counter   <= '0;
              prescaler <= '0;
              busy      <= 1'b1;
            end
          end
          RUN: begin
            // stop wins over both tick and start; the prescaler is frozen as-is
            if (stop) begin
              st <= PAUSE;
            end else if (tick) begin
              prescaler <= '0;
              if (counter != tc) begin
                counter <= counter + 12'd1;
              end else if (mode) begin
                counter <= '0;
                wrap    <= 1'b1;
              end else begin
                st   <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
          PAUSE: begin
            if (start) st <= RUN;
          end
          DONE: begin
            if (tc_load) tc <= tc_value;
            if (start) begin
              st        <= RUN;
              counter   <= '0;
              prescaler <= '0;
              busy      <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
